ifu_fetch_stage: RTL

// - Instruction fetch stage: owns the PC and issues fch_req to instruction memory.
// - Queues fch_rsp instruction words with their PCs and presents them to execute over ex_req.
// - Consumes ex_rsp; a taken branch redirects the PC and flushes wrong-path instructions.
// - Sits between the I-side memory port and the execute stage.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_fetch_stage_fifo.sv | 77 +++++++
 rtl/ifu_fetch_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch stage
package ifu_pkg;

   localparam int PC_W = 32;
   localparam int IR_W = 32;

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   typedef logic [IR_W-1:0] rv32i_inst_t;

   typedef struct packed {
      rv32i_inst_t     ir;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;

   // Branch targets are forced onto a word boundary before they become the fetch pc.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch_stage_fifo.sv
// rtl/ifu_fetch_stage_fifo.sv - synchronous FIFO with flush, used for the instruction buffer and pc queue
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   push_i, push_data_i     write one entry (ignored when full or flushing)
//   pop_i                   drop the head entry (ignored when empty)
//   flush_i                 empty the FIFO; wins over a same-cycle push
//   pop_data_o              head entry, valid while !empty_o
//   full_o, empty_o, count_o  occupancy
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign push_ok    = push_i && !full_o && !flush_i;
   assign pop_ok     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/ifu_fetch_stage.sv
// rtl/ifu_fetch_stage.sv - instruction fetch stage: pc owner, fetch issue, instruction buffer, redirect
// Ports:
//   clk_i, rst_n_i                         clock, synchronous active-low reset
//   fch_req_{vld_o,rdy_i,pc_o}             fetch request to instruction memory
//   fch_rsp_{vld_i,rdy_o,ir_i}             in-order instruction word from memory
//   ex_req_{vld_o,rdy_i,ir_o,pc_o,valid_o} instruction presented to execute
//   ex_rsp_{vld_i,rdy_o,taken_i,target_pc_i} execute completion / branch outcome
module ifu_fetch_stage
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4,
   parameter int          MAX_OS    = 2
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   output logic            fch_req_vld_o,
   input  logic            fch_req_rdy_i,
   output logic [PC_W-1:0] fch_req_pc_o,
   input  logic            fch_rsp_vld_i,
   output logic            fch_rsp_rdy_o,
   input  logic [IR_W-1:0] fch_rsp_ir_i,
   output logic            ex_req_vld_o,
   input  logic            ex_req_rdy_i,
   output logic [IR_W-1:0] ex_req_ir_o,
   output logic [PC_W-1:0] ex_req_pc_o,
   output logic            ex_req_valid_o,
   input  logic            ex_rsp_vld_i,
   output logic            ex_rsp_rdy_o,
   input  logic            ex_rsp_taken_i,
   input  logic [PC_W-1:0] ex_rsp_target_pc_i
);

   localparam int OS_W = $clog2(MAX_OS + 1);
   localparam int BC_W = $clog2(BUF_DEPTH + 1);

   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] redir_pc_q, redir_pc_d;
   logic            redir_pend_q, redir_pend_d;
   logic [OS_W-1:0] drop_cnt_q, drop_cnt_d;
   logic            ex_busy_q, ex_busy_d;
   logic            run_q;

   logic            fch_hs, fch_held, rsp_hs, rsp_drop, ex_hs, exr_hs, redirect;
   logic [OS_W-1:0] os_cnt, os_cnt_next;
   logic [BC_W-1:0] buf_cnt;
   logic            buf_full, buf_empty, pcq_full, pcq_empty;
   logic [PC_W-1:0] pcq_head;
   fetch_entry_t    buf_in, buf_head;

   // os_cnt is the pc queue occupancy: one entry per request awaiting its response.
   // Space is reserved in the buffer for every outstanding request, so a response push never overflows.
   // run_q keeps the request low in the cycle right after reset.
   assign fch_req_vld_o = run_q && !pcq_full && !buf_full &&
                          ((int'(buf_cnt) + int'(os_cnt)) < BUF_DEPTH);
   assign fch_req_pc_o  = fetch_pc_q;
   assign fch_rsp_rdy_o = 1'b1;

   assign ex_req_vld_o   = !buf_empty && !ex_busy_q;
   assign ex_req_ir_o    = buf_head.ir;
   assign ex_req_pc_o    = buf_head.pc;
   assign ex_req_valid_o = 1'b1;
   assign ex_rsp_rdy_o   = ex_busy_q;

   assign fch_hs   = fch_req_vld_o && fch_req_rdy_i;
   assign fch_held = fch_req_vld_o && !fch_req_rdy_i;
   assign rsp_hs   = fch_rsp_vld_i && !pcq_empty;
   assign rsp_drop = rsp_hs && (drop_cnt_q != '0);
   assign ex_hs    = ex_req_vld_o && ex_req_rdy_i;
   assign exr_hs   = ex_rsp_vld_i && ex_busy_q;
   assign redirect = exr_hs && ex_rsp_taken_i;

   assign os_cnt_next = os_cnt + OS_W'(fch_hs) - OS_W'(rsp_hs);

   assign buf_in.ir = fch_rsp_ir_i;
   assign buf_in.pc = pcq_head;

   sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OS)) u_pc_queue (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (fch_hs),
      .push_data_i(fetch_pc_q),
      .pop_i      (rsp_hs),
      .flush_i    (1'b0),
      .pop_data_o (pcq_head),
      .full_o     (pcq_full),
      .empty_o    (pcq_empty),
      .count_o    (os_cnt)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_buf (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (rsp_hs && !rsp_drop),
      .push_data_i(buf_in),
      .pop_i      (ex_hs),
      .flush_i    (redirect),
      .pop_data_o (buf_head),
      .full_o     (buf_full),
      .empty_o    (buf_empty),
      .count_o    (buf_cnt)
   );

   // A request held at redirect time must keep its old pc until accepted, so the
   // target is parked in redir_pc_q and becomes the fetch pc on that acceptance.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      if (fch_hs) begin
         fetch_pc_d   = redir_pend_q ? redir_pc_q : fetch_pc_q + PC_STEP;
         redir_pend_d = 1'b0;
      end
      if (redirect) begin
         if (fch_held) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = align_pc(ex_rsp_target_pc_i);
         end else begin
            fetch_pc_d = align_pc(ex_rsp_target_pc_i);
         end
      end
   end

   // Every request already accepted or still held at redirect belongs to the wrong path.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - OS_W'(1);
      if (redirect) drop_cnt_d = os_cnt_next + OS_W'(fch_held);
   end

   always_comb begin
      ex_busy_d = ex_busy_q;
      if (ex_hs)  ex_busy_d = 1'b1;
      if (exr_hs) ex_busy_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         fetch_pc_q   <= RESET_PC;
         redir_pc_q   <= '0;
         redir_pend_q <= 1'b0;
         drop_cnt_q   <= '0;
         ex_busy_q    <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         drop_cnt_q   <= drop_cnt_d;
         ex_busy_q    <= ex_busy_d;
         run_q        <= 1'b1;
      end
   end

endmodule
